m_led_pattern: RTL and testbench

//  Parametrised multi-mode LED pattern generator for the Arty A7 boards; successor to the plain

---
 rtl/m_led_pattern.sv | 153 +++++++++++++++
 tb/tb_m_led_pattern.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/m_led_pattern.sv
// Multi-mode LED pattern generator: binary count, per-channel PWM, breathing and bounce scan,
// all advanced by one shared prescaler step. Every output is registered.
module m_led_pattern #(
  parameter int N_LED    = 4,
  parameter int DIV_BITS = 22,
  parameter int PWM_BITS = 8
) (
  input  logic                      w_clk,
  input  logic                      w_rst_n,
  input  logic [1:0]                w_mode,
  input  logic [N_LED*PWM_BITS-1:0] w_duty,
  output logic                      w_step,
  output logic [N_LED-1:0]          w_led
);

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_PWM     = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_SCAN    = 2'd3
  } mode_e;

  localparam logic [DIV_BITS-1:0] PRE_ONE  = DIV_BITS'(1);
  localparam logic [DIV_BITS-1:0] PRE_MAX  = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] LVL_TOP  = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [N_LED-1:0]    CNT_ONE  = N_LED'(1);
  localparam logic [N_LED-1:0]    POS_INIT = N_LED'(1);

  logic [DIV_BITS-1:0] pre_q, pre_d;
  logic                wrap_q, wrap_d;
  logic                step_q, step_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  mode_e               mode_q, mode_d;
  logic [N_LED-1:0]    cnt_q, cnt_d;
  logic [PWM_BITS-1:0] lvl_q, lvl_d;
  logic                lvl_down_q, lvl_down_d;
  logic [N_LED-1:0]    pos_q, pos_d;
  logic                pos_down_q, pos_down_d;
  logic [N_LED-1:0]    led_q, led_d;

  assign w_step = step_q;
  assign w_led  = led_q;

  // Timebase: wrap_q marks the all-ones->0 wrap, step_q fires the cycle after it.
  always_comb begin
    pre_d  = pre_q + PRE_ONE;
    pwm_d  = pwm_q + PWM_ONE;
    wrap_d = (pre_q == PRE_MAX);
    step_d = wrap_q;
  end

  // Mode, count and breathing level advance only on step cycles, whatever mode is active.
  always_comb begin
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    lvl_d      = lvl_q;
    lvl_down_d = lvl_down_q;
    if (step_q) begin
      mode_d = mode_e'(w_mode);
      cnt_d  = cnt_q + CNT_ONE;
      if (!lvl_down_q) begin
        lvl_d = lvl_q + PWM_ONE;
        if (lvl_q == LVL_TOP) begin
          lvl_down_d = 1'b1;
        end else begin
          lvl_down_d = 1'b0;
        end
      end else begin
        lvl_d = lvl_q - PWM_ONE;
        if (lvl_q == PWM_ONE) begin
          lvl_down_d = 1'b0;
        end else begin
          lvl_down_d = 1'b1;
        end
      end
    end else begin
      mode_d = mode_q;
    end
  end

  // Bounce scan: turn around once the lit bit reaches either end.
  generate
    if (N_LED == 1) begin : g_scan_single
      always_comb begin
        pos_d      = POS_INIT;
        pos_down_d = 1'b0;
      end
    end else begin : g_scan_multi
      always_comb begin
        pos_d      = pos_q;
        pos_down_d = pos_down_q;
        if (step_q) begin
          if (!pos_down_q) begin
            pos_d      = pos_q << 1;
            pos_down_d = pos_q[N_LED-2];
          end else begin
            pos_d      = pos_q >> 1;
            pos_down_d = !pos_q[1];
          end
        end else begin
          pos_d = pos_q;
        end
      end
    end
  endgenerate

  // LED drive for the active mode, registered next edge.
  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_COUNT: led_d = cnt_q;
      MODE_PWM: begin
        for (int i = 0; i < N_LED; i++) begin
          led_d[i] = (pwm_q < w_duty[i*PWM_BITS +: PWM_BITS]);
        end
      end
      MODE_BREATHE: led_d = {N_LED{(pwm_q < lvl_q)}};
      MODE_SCAN:    led_d = pos_q;
      default:      led_d = '0;
    endcase
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      pre_q      <= '0;
      wrap_q     <= 1'b0;
      step_q     <= 1'b0;
      pwm_q      <= '0;
      mode_q     <= MODE_COUNT;
      cnt_q      <= '0;
      lvl_q      <= '0;
      lvl_down_q <= 1'b0;
      pos_q      <= POS_INIT;
      pos_down_q <= 1'b0;
      led_q      <= '0;
    end else begin
      pre_q      <= pre_d;
      wrap_q     <= wrap_d;
      step_q     <= step_d;
      pwm_q      <= pwm_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_down_q <= lvl_down_d;
      pos_q      <= pos_d;
      pos_down_q <= pos_down_d;
      led_q      <= led_d;
    end
  end

endmodule

// File: tb/tb_m_led_pattern.sv
// Self-checking bench for m_led_pattern (N_LED=4, DIV_BITS=4, PWM_BITS=4): a cycle-level
// reference derived from elapsed edges and step count, plus PWM on-count vectors and directed corners.
module tb_m_led_pattern;

  localparam int N_LED    = 4;
  localparam int DIV_BITS = 4;
  localparam int PWM_BITS = 4;

  logic                      w_clk = 1'b0;
  logic                      w_rst_n = 1'b0;
  logic [1:0]                w_mode = 2'd0;
  logic [N_LED*PWM_BITS-1:0] w_duty = 16'h0000;
  logic                      w_step;
  logic [N_LED-1:0]          w_led;

  int checks = 0;
  int failures = 0;

  // reference: edges since reset release, pattern steps taken, latched mode
  int         t = 0;
  int         n = 0;
  logic [1:0] mode_m = 2'd0;
  logic       model_on = 1'b0;

  typedef struct {
    logic [15:0]      duty;
    logic [3:0][4:0]  on;
  } pwm_vec_t;
  pwm_vec_t tbl [4];

  m_led_pattern #(.N_LED(N_LED), .DIV_BITS(DIV_BITS), .PWM_BITS(PWM_BITS)) dut (
    .w_clk  (w_clk),
    .w_rst_n(w_rst_n),
    .w_mode (w_mode),
    .w_duty (w_duty),
    .w_step (w_step),
    .w_led  (w_led)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [3:0] exp_out(input logic [1:0] md, input int nn, input int pwm,
                                         input logic [15:0] duty);
    logic [3:0] r;
    int m;
    int lvl;
    int idx;
    r = 4'h0;
    case (md)
      2'd0: r = 4'(nn % 16);
      2'd1: for (int i = 0; i < 4; i++) r[i] = (pwm < int'(duty[i*4 +: 4]));
      2'd2: begin
        m   = nn % 30;
        lvl = (m <= 15) ? m : 30 - m;
        r   = (pwm < lvl) ? 4'hF : 4'h0;
      end
      default: begin
        m   = nn % 6;
        idx = (m <= 3) ? m : 6 - m;
        r   = 4'b0001 << idx;
      end
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic tick();
    logic [3:0] e;
    logic       es;
    logic [1:0] md;
    md = w_mode;
    e  = exp_out(mode_m, n, t % 16, w_duty);
    @(posedge w_clk);
    t++;
    if (t >= 18 && (t - 18) % 16 == 0) begin
      n++;
      mode_m = md;
    end
    es = (t >= 17 && (t - 17) % 16 == 0);
    #1;
    if (model_on) begin
      check("led", 32'(w_led), 32'(e));
      check("step", 32'(w_step), 32'(es));
    end
  endtask

  task automatic release_reset();
    w_rst_n  = 1'b1;
    t        = 0;
    n        = 0;
    mode_m   = 2'd0;
    model_on = 1'b1;
  endtask

  task automatic wait_mode(input logic [1:0] m);
    for (int i = 0; i < 40 && mode_m != m; i++) tick();
    check("mode_latch_timeout", 32'(mode_m), 32'(m));
  endtask

  initial begin
    int cnt [4];
    int edges;

    tbl[0].duty = 16'h0F81; tbl[0].on = {5'd0, 5'd15, 5'd8, 5'd1};
    tbl[1].duty = 16'hFFFF; tbl[1].on = {5'd15, 5'd15, 5'd15, 5'd15};
    tbl[2].duty = 16'h0000; tbl[2].on = {5'd0, 5'd0, 5'd0, 5'd0};
    tbl[3].duty = 16'h5432; tbl[3].on = {5'd5, 5'd4, 5'd3, 5'd2};

    #2;
    check("rst_led", 32'(w_led), 32'h0);
    check("rst_step", 32'(w_step), 32'h0);
    @(posedge w_clk);
    #1;
    release_reset();

    // COUNT held: reach count 10 (1010), then reset asynchronously mid-run
    w_mode = 2'd0;
    while (t < 163) tick();
    check("count_10", 32'(w_led), 32'hA);
    #2;
    w_rst_n  = 1'b0;
    model_on = 1'b0;
    #1;
    check("async_rst_led", 32'(w_led), 32'h0);
    check("async_rst_step", 32'(w_step), 32'h0);
    @(posedge w_clk);
    @(posedge w_clk);
    #1;
    release_reset();
    edges = 0;
    for (int i = 0; i < 40 && w_step !== 1'b1; i++) begin
      tick();
      edges++;
    end
    check("first_step_edges", 32'(edges), 32'd17);

    // full COUNT wrap past 16 steps
    while (n < 18) tick();

    // mode 0->3 three clocks after a step
    for (int i = 0; i < 40 && w_step !== 1'b1; i++) tick();
    tick();
    tick(); tick(); tick();
    w_mode = 2'd3;
    for (int i = 0; i < 40 && w_step !== 1'b1; i++) tick();
    tick();
    tick();
    check("switch_scan_onehot", 32'($onehot(w_led)), 32'd1);

    // SCAN and BREATHE over full periods
    while (n < 40) tick();
    w_mode = 2'd2;
    wait_mode(2'd2);
    while (n < 75) tick();

    // PWM duty vectors: on-count per channel over a 16-clock window
    w_mode = 2'd1;
    wait_mode(2'd1);
    for (int k = 0; k < 4; k++) begin
      w_duty = tbl[k].duty;
      tick();
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      for (int j = 0; j < 16; j++) begin
        tick();
        for (int c = 0; c < 4; c++) cnt[c] += int'(w_led[c]);
      end
      for (int c = 0; c < 4; c++)
        check($sformatf("pwm_on_v%0d_ch%0d", k, c), 32'(cnt[c]), 32'(tbl[k].on[c]));
    end

    // random modes and duties against the reference
    for (int s = 0; s < 120; s++) begin
      w_mode = 2'($urandom_range(0, 3));
      w_duty = 16'($urandom);
      for (int j = 0; j < int'($urandom_range(1, 40)); j++) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
